// File: rtl/demux_scan_ctrl.sv
// Sequencer feeding a combinational 1xN demux: one N-bit frame per handshake,
// routed bit k -> channel k over N cycles. Optional feature macro: DEMUX_SCAN_DWELL_EN.
module demux_scan_ctrl #(
  parameter int N     = 4,
  parameter int DWELL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  output logic                 en,
  output logic                 i,
  output logic [$clog2(N)-1:0] s,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (N < 2) begin : g_bad_n
    $error("demux_scan_ctrl: N must be >= 2");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("demux_scan_ctrl: DWELL must be >= 1");
  end

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  frame, frame_n;
  logic [IW-1:0] s_n;
  logic          i_n, en_n, busy_n, done_n;
  logic          chan_end;

`ifdef DEMUX_SCAN_DWELL_EN
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

  logic [DW-1:0] dcnt, dcnt_n;

  assign chan_end = (dcnt == DLAST);
`else
  assign chan_end = 1'b1;
`endif

  assign in_ready = (state == IDLE);

  // The s register doubles as the channel index; it is forced to 0 outside
  // SCAN so the demux sees a clean all-zero output while idle.
  always_comb begin
    state_n = state;
    frame_n = frame;
    s_n     = s;
    i_n     = i;
    en_n    = en;
    busy_n  = busy;
    done_n  = 1'b0;
`ifdef DEMUX_SCAN_DWELL_EN
    dcnt_n  = dcnt;
`endif
    case (state)
      IDLE: begin
        s_n    = '0;
        i_n    = 1'b0;
        en_n   = 1'b0;
        busy_n = 1'b0;
        if (in_valid && in_ready) begin
          state_n = SCAN;
          frame_n = in_data;
          i_n     = in_data[0];
          en_n    = 1'b1;
          busy_n  = 1'b1;
`ifdef DEMUX_SCAN_DWELL_EN
          dcnt_n  = '0;
`endif
        end
      end
      SCAN: begin
        if (chan_end) begin
`ifdef DEMUX_SCAN_DWELL_EN
          dcnt_n = '0;
`endif
          if (s == LAST) begin
            state_n = IDLE;
            s_n     = '0;
            i_n     = 1'b0;
            en_n    = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            s_n = s + IW'(1);
            i_n = frame[s_n];
          end
        end
`ifdef DEMUX_SCAN_DWELL_EN
        else begin
          dcnt_n = dcnt + DW'(1);
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      frame <= '0;
      s     <= '0;
      i     <= 1'b0;
      en    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef DEMUX_SCAN_DWELL_EN
      dcnt  <= '0;
`endif
    end else begin
      state <= state_n;
      frame <= frame_n;
      s     <= s_n;
      i     <= i_n;
      en    <= en_n;
      busy  <= busy_n;
      done  <= done_n;
`ifdef DEMUX_SCAN_DWELL_EN
      dcnt  <= dcnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Self-checking bench for demux_scan_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a frame-schedule reference model.
module tb_demux_scan_ctrl;

`ifdef DEMUX_SCAN_DWELL_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       v4, v5;
  logic [3:0] d4;
  logic [4:0] d5;
  logic       in_ready4, en4, i4, busy4, done4;
  logic [1:0] s4;
  logic       in_ready5, en5, i5, busy5, done5;
  logic [2:0] s5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  demux_scan_ctrl #(.N(4), .DWELL(3)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(in_ready4), .in_data(d4),
    .en(en4), .i(i4), .s(s4), .busy(busy4), .done(done4)
  );

  demux_scan_ctrl #(.N(5), .DWELL(3)) u5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(in_ready5), .in_data(d5),
    .en(en5), .i(i5), .s(s5), .busy(busy5), .done(done5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pos is the position in the frame schedule of n*D scan
  // cycles followed by one done cycle; -1 means idle.
  int         pos[2] = '{-1, -1};
  logic [7:0] frm[2] = '{8'h00, 8'h00};

  function automatic int m_busy(input int u, input int n);
    return (pos[u] >= 0 && pos[u] < n * D) ? 1 : 0;
  endfunction

  function automatic int m_ch(input int u, input int n);
    return (m_busy(u, n) != 0) ? pos[u] / D : 0;
  endfunction

  function automatic int m_i(input int u, input int n);
    return (m_busy(u, n) != 0) ? int'(frm[u][m_ch(u, n)]) : 0;
  endfunction

  function automatic int m_done(input int u, input int n);
    return (pos[u] == n * D) ? 1 : 0;
  endfunction

  task automatic mstep(input int u, input logic r, input logic v, input logic [7:0] d, input int n);
    if (r) pos[u] = -1;
    else if (m_busy(u, n) != 0) pos[u] = pos[u] + 1;
    else if (v) begin
      pos[u] = 0;
      frm[u] = d;
    end else pos[u] = -1;
  endtask

  always @(posedge clk) begin
    mstep(0, rst, v4, {4'b0, d4}, 4);
    mstep(1, rst, v5, {3'b0, d5}, 5);
  end

  always @(negedge clk) begin
    chk("u4 en", en4, m_busy(0, 4));
    chk("u4 s", s4, m_ch(0, 4));
    chk("u4 i", i4, m_i(0, 4));
    chk("u4 done", done4, m_done(0, 4));
    chk("u4 busy", busy4, m_busy(0, 4));
    chk("u4 in_ready", in_ready4, 1 - m_busy(0, 4));
    chk("u5 en", en5, m_busy(1, 5));
    chk("u5 s", s5, m_ch(1, 5));
    chk("u5 i", i5, m_i(1, 5));
    chk("u5 done", done5, m_done(1, 5));
    chk("u5 in_ready", in_ready5, 1 - m_busy(1, 5));
    chk("u5 s range", (s5 < 3'd5) ? 1 : 0, 1);
  end

  task automatic wait_ready4();
    int n = 0;
    while (in_ready4 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("u4 ready wait", in_ready4, 1);
  endtask

  // Called at the negedge of the first scan cycle; returns at the done cycle.
  task automatic scan4(input string nm, input logic [3:0] ei, input int pulse_at);
    int st = 0;
    for (int k = 0; k < 4; k++) begin
      for (int dd = 0; dd < D; dd++) begin
        chk({nm, " en/s/i"}, {en4, s4, i4}, {1'b1, 2'(k), ei[k]});
        if (pulse_at >= 0 && st == pulse_at) begin
          v4 = 1'b1;
          d4 = 4'b1111;
        end else if (pulse_at >= 0 && st == pulse_at + 1) begin
          v4 = 1'b0;
        end
        st++;
        @(negedge clk);
      end
    end
    chk({nm, " done/en/rdy"}, {done4, en4, in_ready4}, 3'b101);
  endtask

  typedef struct {
    logic [3:0] data;
    logic [3:0] exp_i;
  } vec_t;

  vec_t tbl[5];
  logic seen;

  initial begin
    tbl[0] = '{data: 4'b1011, exp_i: 4'b1011};
    tbl[1] = '{data: 4'b0100, exp_i: 4'b0100};
    tbl[2] = '{data: 4'b0000, exp_i: 4'b0000};
    tbl[3] = '{data: 4'b1111, exp_i: 4'b1111};
    tbl[4] = '{data: 4'b1001, exp_i: 4'b1001};

    rst = 1'b1; v4 = 1'b0; v5 = 1'b0; d4 = '0; d5 = '0;
    repeat (3) @(negedge clk);
    chk("reset state", {en4, s4, i4, busy4, done4, in_ready4}, 7'b0000001);
    rst = 1'b0;
    @(negedge clk);

    // Table of single frames; in_data is scrambled during the scan.
    for (int t = 0; t < 5; t++) begin
      wait_ready4();
      v4 = 1'b1;
      d4 = tbl[t].data;
      @(posedge clk);
      @(negedge clk);
      v4 = 1'b0;
      d4 = ~tbl[t].data;
      scan4($sformatf("vec%0d", t), tbl[t].exp_i, -1);
      @(negedge clk);
    end

    // Back-to-back: in_valid held across the done cycle.
    wait_ready4();
    v4 = 1'b1;
    d4 = 4'b1011;
    @(posedge clk);
    @(negedge clk);
    d4 = 4'b0100;
    scan4("b2b first", 4'b1011, -1);
    @(negedge clk);
    v4 = 1'b0;
    scan4("b2b second", 4'b0100, -1);
    @(negedge clk);

    // in_valid pulsed while busy is ignored.
    wait_ready4();
    v4 = 1'b1;
    d4 = 4'b1011;
    @(posedge clk);
    @(negedge clk);
    v4 = 1'b0;
    scan4("busy ignore", 4'b1011, 1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (en4 !== 1'b0) seen = 1'b1;
    end
    chk("no extra scan", seen, 0);

    // Reset while s == 2 aborts without done.
    wait_ready4();
    v4 = 1'b1;
    d4 = 4'b1011;
    @(posedge clk);
    @(negedge clk);
    v4 = 1'b0;
    repeat (2 * D) @(negedge clk);
    chk("pre-abort s", s4, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort state", {en4, s4, i4, busy4, in_ready4}, 6'b000001);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4 * D + 3) begin
      @(negedge clk);
      if (done4 !== 1'b0) seen = 1'b1;
    end
    chk("no done after abort", seen, 0);

    // Reset together with in_valid: nothing captured.
    rst = 1'b1;
    v4 = 1'b1;
    d4 = 4'b1111;
    @(negedge clk);
    chk("rst+valid en", en4, 0);
    rst = 1'b0;
    v4 = 1'b0;
    @(negedge clk);
    chk("rst+valid not captured", {en4, busy4}, 2'b00);

    // N=5 all-ones frame.
    v5 = 1'b1;
    d5 = 5'b11111;
    @(posedge clk);
    @(negedge clk);
    v5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int dd = 0; dd < D; dd++) begin
        chk("n5 en/s/i", {en5, s5, i5}, {1'b1, 3'(k), 1'b1});
        @(negedge clk);
      end
    end
    chk("n5 done", {done5, en5}, 2'b10);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      v4 = 1'($urandom_range(0, 1));
      d4 = 4'($urandom);
      v5 = 1'($urandom_range(0, 1));
      d5 = 5'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    v4 = 1'b0;
    v5 = 1'b0;
    repeat (5 * D + 5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
